fetch_unit: RTL and testbench
=============================

// Module: fetch_unit
// PURPOSE
//  Instruction fetch stage of the NBBPU, directly upstream of the controller. Holds the program counter,
//  reads 16-bit instruction words from instruction memory over a req/ready handshake, latches them in an
//  instruction register and presents opcode/x/y/z to the controller and register file. It then applies the
//  controller's PC_select to form the next PC once execution of the current instruction completes.
// PARAMETERS
//  PC_WIDTH      16       program counter / instruction address width (word addressed)
//  RESET_VECTOR  16'h0000 PC value loaded on reset
//  HALT_WORD     16'hFFFF instruction word that stops fetching
// PORTS
//  clock          input   1         system clock, all state updates on rising edge
//  reset          input   1         asynchronous, active-low reset
//  instr_req      output  1         instruction memory read request
//  instr_address  output  PC_WIDTH  instruction memory word address (= PC)
//  instr_ready    input   1         memory has instr_data valid this cycle
//  instr_data     input   16        instruction word from memory
//  opcode         output  4         IR[15:12] to controller
//  x              output  4         IR[11:8]
//  y              output  4         IR[7:4]
//  z              output  4         IR[3:0]
//  instr_valid    output  1         IR holds an instruction under execution
//  exec_done      input   1         datapath finished current instruction; PC_select/targets valid
//  PC_select      input   2         00 PC+1, 01 branch_target, 10 jump_target, 11 treated as PC+1
//  branch_target  input   PC_WIDTH  branch/jal destination
//  jump_target    input   PC_WIDTH  jalr destination (register value)
//  PC             output  PC_WIDTH  current program counter
//  PC_plus_one    output  PC_WIDTH  PC+1 (link value for jal/jalr)
//  halted         output  1         HALT_WORD fetched; core stopped
// BEHAVIOUR
//  Reset (async, reset==0): state=START, PC=RESET_VECTOR, IR=16'h0000; outputs instr_req=0, instr_valid=0,
//   halted=0, opcode/x/y/z=0. Takes effect immediately, including mid-fetch or mid-execute; any pending
//   handshake is abandoned and a late instr_ready is ignored.
//  States: START -> FETCH -> EXECUTE -> FETCH ...; EXECUTE -> HALT on halt word. HALT is exited only by reset.
//  START: one cycle after reset release, instr_req=0; unconditionally -> FETCH.
//  FETCH: instr_req=1, instr_address=PC (combinational from state/PC). On a rising edge with instr_ready=1:
//   IR<=instr_data, state->EXECUTE. With instr_ready=0: stay, req held high, address held stable.
//   Minimum fetch latency: 1 cycle (ready in the first FETCH cycle -> instr_valid next cycle).
//  EXECUTE: instr_req=0, instr_valid=1, opcode/x/y/z = IR fields (registered, stable for the whole state).
//   If IR==HALT_WORD: next edge state->HALT, PC unchanged, exec_done ignored.
//   Else on edge with exec_done=1: PC<=next_pc, state->FETCH. exec_done=0: hold.
//  next_pc: PC_select 00/11 -> PC+1; 01 -> branch_target; 10 -> jump_target.
//  PC+1 is modulo 2^PC_WIDTH (PC=all-ones wraps to 0); PC_plus_one uses the same wrap.
//  HALT: instr_req=0, instr_valid=0, halted=1, PC frozen.
//  Ignored inputs: instr_ready outside FETCH; exec_done outside EXECUTE; PC_select/targets except on the
//   exec_done edge.
//  Throughput: at best 2 cycles per instruction (1 FETCH + 1 EXECUTE); no prefetch, no overlap.
// TESTING
//  1 Reset then instr_ready tied 1, memory word 0x1234 at addr 0 -> START 1 cycle, req at addr 0,
//    next cycle opcode=1 x=2 y=3 z=4 instr_valid=1.
//  2 exec_done=1 with PC_select=00 at PC=5 -> next FETCH address 6; PC_select=01, branch_target=0x40 -> 0x40;
//    PC_select=10, jump_target=0x1234 -> 0x1234; PC_select=11 -> PC+1.
//  3 instr_ready held low 7 cycles in FETCH -> req=1 and address constant all 7 cycles; IR loads on 8th.
//  4 PC=16'hFFFF, PC_select=00, exec_done -> PC=0, PC_plus_one was 0 during EXECUTE.
//  5 Fetch 0xFFFF -> EXECUTE 1 cycle, then halted=1, req=0, valid=0; exec_done pulses do not move PC.
//  6 Assert reset mid-FETCH and mid-EXECUTE -> req/valid drop same cycle (async), PC=RESET_VECTOR, restart via START.

Source files
------------

// File: rtl/fetch_unit.sv
// ---------------------------------------------------------------------------
// fetch_unit
// Instruction fetch stage. Holds the program counter, reads one 16-bit
// instruction word per instruction over a req/ready handshake, latches it in
// the instruction register (IR) and presents its fields to the controller.
// Once the datapath reports exec_done, the next PC is selected from PC+1,
// branch_target or jump_target. Fetching the HALT_WORD stops the core until
// reset. There is no prefetch, so the best case is two cycles per instruction
// (one FETCH cycle and one EXECUTE cycle).
//
// Ports
//   clock          system clock, rising edge
//   reset          asynchronous, active-low reset
//   instr_req      instruction memory read request (FETCH only)
//   instr_address  instruction word address (= PC)
//   instr_ready    instr_data is valid this cycle
//   instr_data     instruction word from memory
//   opcode/x/y/z   IR[15:12] / IR[11:8] / IR[7:4] / IR[3:0]
//   instr_valid    IR holds the instruction under execution
//   exec_done      current instruction finished; PC_select/targets valid
//   PC_select      00 PC+1, 01 branch_target, 10 jump_target, 11 PC+1
//   branch_target  branch/jal destination
//   jump_target    jalr destination
//   PC             current program counter
//   PC_plus_one    PC+1 modulo 2^PC_WIDTH (link value)
//   halted         HALT_WORD fetched; core stopped
// ---------------------------------------------------------------------------
module fetch_unit #(
  parameter int                  PC_WIDTH     = 16,
  parameter logic [PC_WIDTH-1:0] RESET_VECTOR = '0,
  parameter logic [15:0]         HALT_WORD    = 16'hFFFF
) (
  input  logic                clock,
  input  logic                reset,
  output logic                instr_req,
  output logic [PC_WIDTH-1:0] instr_address,
  input  logic                instr_ready,
  input  logic [15:0]         instr_data,
  output logic [3:0]          opcode,
  output logic [3:0]          x,
  output logic [3:0]          y,
  output logic [3:0]          z,
  output logic                instr_valid,
  input  logic                exec_done,
  input  logic [1:0]          PC_select,
  input  logic [PC_WIDTH-1:0] branch_target,
  input  logic [PC_WIDTH-1:0] jump_target,
  output logic [PC_WIDTH-1:0] PC,
  output logic [PC_WIDTH-1:0] PC_plus_one,
  output logic                halted
);

  typedef enum logic [1:0] {
    START   = 2'd0,
    FETCH   = 2'd1,
    EXECUTE = 2'd2,
    HALT    = 2'd3
  } state_t;

  localparam logic [PC_WIDTH-1:0] PC_ONE = 1;

  state_t              state, state_next;
  logic [PC_WIDTH-1:0] pc_q, pc_next, pc_inc;
  logic [15:0]         ir_q;
  logic                ir_load, pc_load;

  // Natural overflow of the adder gives the required wrap from all-ones to 0.
  assign pc_inc = pc_q + PC_ONE;

  always_comb begin
    case (PC_select)
      2'b01:   pc_next = branch_target;
      2'b10:   pc_next = jump_target;
      default: pc_next = pc_inc;   // 00 and the unused 11 both advance
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values of the others; blocking here would create ordering races.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= START;
    else        state <= state_next;
  end

  // Reset clears IR so opcode/x/y/z read zero straight out of reset.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pc_q <= RESET_VECTOR;
      ir_q <= 16'h0000;
    end else begin
      if (ir_load) ir_q <= instr_data;
      if (pc_load) pc_q <= pc_next;
    end
  end

  // Handshake outputs are decoded from state rather than registered, so an
  // asynchronous reset drops req/valid in the same cycle it is asserted.
  always_comb begin
    // NOTE: every output of this block is given a default first; a path that
    // leaves one unassigned would infer a latch.
    state_next  = state;
    instr_req   = 1'b0;
    instr_valid = 1'b0;
    halted      = 1'b0;
    ir_load     = 1'b0;
    pc_load     = 1'b0;
    case (state)
      START: state_next = FETCH;
      FETCH: begin
        instr_req = 1'b1;
        if (instr_ready) begin
          ir_load    = 1'b1;
          state_next = EXECUTE;
        end
      end
      EXECUTE: begin
        instr_valid = 1'b1;
        // A halt word ignores exec_done and leaves the PC untouched.
        if (ir_q == HALT_WORD) begin
          state_next = HALT;
        end else if (exec_done) begin
          pc_load    = 1'b1;
          state_next = FETCH;
        end
      end
      HALT:    halted = 1'b1;
      default: state_next = START;
    endcase
  end

  assign instr_address = pc_q;
  assign PC            = pc_q;
  assign PC_plus_one   = pc_inc;
  assign opcode        = ir_q[15:12];
  assign x             = ir_q[11:8];
  assign y             = ir_q[7:4];
  assign z             = ir_q[3:0];

endmodule

// File: tb/tb_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_fetch_unit
// Self-checking bench for fetch_unit. A table of instructions walks the PC
// through every PC_select option, fetch wait states and the all-ones wrap;
// hand-written sequences cover halt and asynchronous reset mid-FETCH and
// mid-EXECUTE. Expected IR words and next fetch addresses go into queues
// when stimulus is driven and are popped when the DUT presents them.
// ---------------------------------------------------------------------------
module tb_fetch_unit;

  logic        clock = 1'b0;
  logic        reset;
  logic        instr_req;
  logic [15:0] instr_address;
  logic        instr_ready;
  logic [15:0] instr_data;
  logic [3:0]  opcode, x, y, z;
  logic        instr_valid;
  logic        exec_done;
  logic [1:0]  PC_select;
  logic [15:0] branch_target, jump_target;
  logic [15:0] PC, PC_plus_one;
  logic        halted;

  int n_pass  = 0;
  int n_total = 0;

  logic [15:0] exp_ir_q[$];
  logic [15:0] exp_pc_q[$];

  typedef struct {
    logic [15:0] pc;        // address expected for this fetch
    logic [15:0] instr;     // word returned by memory
    int          delay;     // cycles instr_ready stays low first
    logic [1:0]  sel;
    logic [15:0] bt;
    logic [15:0] jt;
    logic [15:0] next_pc;   // expected address of the following fetch
    bit          hold;      // spend one EXECUTE cycle with exec_done low
  } vec_t;

  vec_t vecs[7];

  fetch_unit #(
    .PC_WIDTH     (16),
    .RESET_VECTOR (16'h0000),
    .HALT_WORD    (16'hFFFF)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .instr_req     (instr_req),
    .instr_address (instr_address),
    .instr_ready   (instr_ready),
    .instr_data    (instr_data),
    .opcode        (opcode),
    .x             (x),
    .y             (y),
    .z             (z),
    .instr_valid   (instr_valid),
    .exec_done     (exec_done),
    .PC_select     (PC_select),
    .branch_target (branch_target),
    .jump_target   (jump_target),
    .PC            (PC),
    .PC_plus_one   (PC_plus_one),
    .halted        (halted)
  );

  always #5 clock = ~clock;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h required %0h", name, act, exp);
  endtask

  task automatic check_fields(input string name, input logic [15:0] w);
    check({name, "_opcode"}, opcode, w[15:12]);
    check({name, "_x"}, x, w[11:8]);
    check({name, "_y"}, y, w[7:4]);
    check({name, "_z"}, z, w[3:0]);
  endtask

  // Called in a FETCH cycle; returns in the first EXECUTE cycle.
  task automatic fetch_word(input logic [15:0] addr, input logic [15:0] word, input int delay);
    logic [15:0] w;
    for (int i = 0; i < delay; i++) begin
      instr_ready = 1'b0;
      instr_data  = 16'hDEAD;
      check("wait_req", instr_req, 1);
      check("wait_addr", instr_address, addr);
      check("wait_valid", instr_valid, 0);
      tick();
    end
    check("fetch_req", instr_req, 1);
    check("fetch_addr", instr_address, addr);
    instr_ready = 1'b1;
    instr_data  = word;
    exp_ir_q.push_back(word);
    tick();
    instr_ready = 1'b0;
    instr_data  = 16'hDEAD;
    check("exec_valid", instr_valid, 1);
    check("exec_req", instr_req, 0);
    if (exp_ir_q.size() == 0) begin
      check("ir_scoreboard_nonempty", 0, 1);
    end else begin
      w = exp_ir_q.pop_front();
      check_fields("ir", w);
    end
  endtask

  // Called in an EXECUTE cycle; returns in the next FETCH cycle.
  task automatic exec_instr(input vec_t v);
    logic [15:0] p1, w, got;
    int          n;
    p1 = v.pc + 16'd1;
    w  = v.instr;
    check("exec_pc", PC, v.pc);
    check("exec_pc_plus_one", PC_plus_one, p1);
    if (v.hold) begin
      // Stray ready and changing selects must not disturb EXECUTE.
      exec_done     = 1'b0;
      PC_select     = ~v.sel;
      branch_target = 16'hBEEF;
      jump_target   = 16'hCAFE;
      instr_ready   = 1'b1;
      instr_data    = 16'h0000;
      tick();
      instr_ready = 1'b0;
      check("hold_valid", instr_valid, 1);
      check("hold_pc", PC, v.pc);
      check_fields("hold_ir", w);
    end
    exec_done     = 1'b1;
    PC_select     = v.sel;
    branch_target = v.bt;
    jump_target   = v.jt;
    exp_pc_q.push_back(v.next_pc);
    tick();
    exec_done     = 1'b0;
    PC_select     = 2'b01;
    branch_target = 16'h5A5A;
    jump_target   = 16'hA5A5;
    n = 0;
    while (instr_req !== 1'b1 && n < 8) begin
      tick();
      n++;
    end
    check("next_fetch_seen", instr_req, 1);
    if (exp_pc_q.size() != 0) begin
      got = instr_address;
      check("next_fetch_addr", got, exp_pc_q.pop_front());
    end
  endtask

  initial begin
    vecs[0] = '{pc:16'h0000, instr:16'h1234, delay:0, sel:2'b01, bt:16'h0005, jt:16'h0000, next_pc:16'h0005, hold:1'b0};
    vecs[1] = '{pc:16'h0005, instr:16'h5A3C, delay:0, sel:2'b00, bt:16'h0999, jt:16'h0888, next_pc:16'h0006, hold:1'b1};
    vecs[2] = '{pc:16'h0006, instr:16'h0001, delay:2, sel:2'b01, bt:16'h0040, jt:16'h0777, next_pc:16'h0040, hold:1'b0};
    vecs[3] = '{pc:16'h0040, instr:16'hABCD, delay:0, sel:2'b10, bt:16'h0111, jt:16'h1234, next_pc:16'h1234, hold:1'b1};
    vecs[4] = '{pc:16'h1234, instr:16'h7777, delay:7, sel:2'b11, bt:16'h0222, jt:16'h0333, next_pc:16'h1235, hold:1'b0};
    vecs[5] = '{pc:16'h1235, instr:16'h0F0F, delay:1, sel:2'b10, bt:16'h0444, jt:16'hFFFF, next_pc:16'hFFFF, hold:1'b0};
    vecs[6] = '{pc:16'hFFFF, instr:16'h2222, delay:0, sel:2'b00, bt:16'h0555, jt:16'h0666, next_pc:16'h0000, hold:1'b0};

    reset         = 1'b0;
    instr_ready   = 1'b0;
    instr_data    = 16'h0000;
    exec_done     = 1'b0;
    PC_select     = 2'b00;
    branch_target = 16'h0000;
    jump_target   = 16'h0000;

    // Reset state
    repeat (2) tick();
    check("rst_req", instr_req, 0);
    check("rst_valid", instr_valid, 0);
    check("rst_halted", halted, 0);
    check("rst_pc", PC, 16'h0000);
    check_fields("rst", 16'h0000);

    // START lasts exactly one cycle with no request
    reset = 1'b1;
    check("start_req", instr_req, 0);
    check("start_valid", instr_valid, 0);
    tick();

    foreach (vecs[i]) begin
      fetch_word(vecs[i].pc, vecs[i].instr, vecs[i].delay);
      exec_instr(vecs[i]);
    end

    // Halt word: one EXECUTE cycle, exec_done ignored, then frozen
    fetch_word(16'h0000, 16'hFFFF, 1);
    exec_done     = 1'b1;
    PC_select     = 2'b01;
    branch_target = 16'h0055;
    tick();
    check("halt_halted", halted, 1);
    check("halt_req", instr_req, 0);
    check("halt_valid", instr_valid, 0);
    check("halt_pc", PC, 16'h0000);
    for (int i = 0; i < 4; i++) begin
      exec_done = ~exec_done;
      tick();
    end
    exec_done = 1'b0;
    check("halt_pc_frozen", PC, 16'h0000);
    check("halt_still", halted, 1);

    // Reset leaves HALT
    reset = 1'b0;
    #1;
    check("halt_rst_halted", halted, 0);
    tick();
    reset = 1'b1;
    check("halt_rst_start_req", instr_req, 0);
    tick();

    // Move PC off the reset vector, then reset asynchronously mid-FETCH
    fetch_word(16'h0000, 16'h3000, 0);
    exec_instr('{pc:16'h0000, instr:16'h3000, delay:0, sel:2'b01, bt:16'h0040, jt:16'h0000, next_pc:16'h0040, hold:1'b0});
    #1;
    reset       = 1'b0;
    instr_ready = 1'b1;
    instr_data  = 16'h4567;
    #1;
    check("rf_req", instr_req, 0);
    check("rf_pc", PC, 16'h0000);
    check("rf_valid", instr_valid, 0);
    tick();
    tick();
    reset = 1'b1;   // late ready still high through START
    check("rf_start_req", instr_req, 0);
    check_fields("rf_ir_clear", 16'h0000);
    tick();
    instr_ready = 1'b0;
    check("rf_refetch_req", instr_req, 1);
    check("rf_refetch_addr", instr_address, 16'h0000);
    check("rf_refetch_valid", instr_valid, 0);

    // Asynchronous reset mid-EXECUTE, with exec_done asserted
    fetch_word(16'h0000, 16'h9ABC, 0);
    #1;
    exec_done     = 1'b1;
    PC_select     = 2'b01;
    branch_target = 16'h0077;
    reset         = 1'b0;
    #1;
    check("re_valid", instr_valid, 0);
    check("re_req", instr_req, 0);
    check_fields("re_ir_clear", 16'h0000);
    tick();
    exec_done = 1'b0;
    reset     = 1'b1;
    check("re_pc", PC, 16'h0000);
    check("re_start_req", instr_req, 0);
    tick();
    check("re_refetch_req", instr_req, 1);
    check("re_refetch_addr", instr_address, 16'h0000);

    check("scoreboard_empty", exp_ir_q.size() + exp_pc_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
